// File: rtl/param_voting_machine.sv
// Password-gated voting machine: one vote per voter ID, saturating per-candidate counts,
// and a sequential tally that reports the lowest-index winner plus a tie indication.
module param_voting_machine #(
  parameter int unsigned     NUM_CAND  = 4,
  parameter int unsigned     VID_W     = 5,
  parameter int unsigned     CNT_W     = 8,
  parameter int unsigned     PW_W      = 4,
  parameter logic [PW_W-1:0] PASSWORD  = 4'b1010,
  parameter int unsigned     MAX_TRIES = 3,
  parameter int unsigned     CIDX_W    = $clog2(NUM_CAND)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [PW_W-1:0]           admin_password,
  input  logic                      enable_admin,
  input  logic                      result_mode,
  input  logic [VID_W-1:0]          voter_id,
  input  logic [NUM_CAND-1:0]       vote,
  output logic [NUM_CAND*CNT_W-1:0] counts,
  output logic [VID_W:0]            total_votes,
  output logic [CIDX_W-1:0]         winner,
  output logic                      winner_valid,
  output logic                      tie_flag,
  output logic                      voting_enabled,
  output logic                      busy,
  output logic                      reject,
  output logic                      admin_locked
);

  localparam int unsigned FailW     = $clog2(MAX_TRIES + 1);
  localparam int unsigned TotW      = VID_W + 1;
  localparam int unsigned NumVoters = 2 ** VID_W;

  typedef enum logic [2:0] {
    StAuth, StIdle, StVote, StLock, StTally, StDone, StLockout
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]     cnt_q [NUM_CAND];
  logic [TotW-1:0]      total_q;
  logic [NumVoters-1:0] voted_q;
  logic [FailW-1:0]     fail_q;
  logic [CIDX_W-1:0]    cand_q;
  logic [VID_W-1:0]     vid_q;
  logic                 reject_q;
  logic [CIDX_W-1:0]    tally_idx_q;
  logic [CNT_W-1:0]     max_q;
  logic [CIDX_W-1:0]    win_q;
  logic                 tie_q;

  logic              vote_nz, vote_onehot, vote_ok, pw_ok, last_try, tally_last;
  logic [CIDX_W-1:0] vote_idx;
  logic [CNT_W-1:0]  cur_cnt;

  always_comb begin
    vote_idx = '0;
    for (int k = 0; k < NUM_CAND; k++) begin
      if (vote[k]) vote_idx = CIDX_W'(k);
    end
    vote_nz     = |vote;
    vote_onehot = vote_nz && ((vote & (vote - NUM_CAND'(1))) == '0);
    vote_ok     = vote_onehot && !voted_q[voter_id];
    pw_ok       = (admin_password == PASSWORD);
    last_try    = (fail_q == FailW'(MAX_TRIES - 1));
    tally_last  = (tally_idx_q == CIDX_W'(NUM_CAND - 1));
    cur_cnt     = cnt_q[tally_idx_q];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= StAuth;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAuth: begin
        if (enable_admin) begin
          if (pw_ok)         state_d = StIdle;
          else if (last_try) state_d = StLockout;
        end
      end
      StIdle: begin
        // Closing the poll wins over a ballot presented in the same cycle.
        if (result_mode)  state_d = StTally;
        else if (vote_nz) state_d = vote_ok ? StVote : StLock;
      end
      StVote:  state_d = StLock;
      StLock:  if (!vote_nz) state_d = StIdle;
      StTally: if (tally_last) state_d = StDone;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CAND; k++) cnt_q[k] <= '0;
      total_q     <= '0;
      voted_q     <= '0;
      fail_q      <= '0;
      cand_q      <= '0;
      vid_q       <= '0;
      reject_q    <= 1'b0;
      tally_idx_q <= '0;
      max_q       <= '0;
      win_q       <= '0;
      tie_q       <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      case (state_q)
        StAuth: begin
          if (enable_admin) fail_q <= pw_ok ? '0 : fail_q + FailW'(1);
        end
        StIdle: begin
          if (result_mode) begin
            tally_idx_q <= '0;
          end else if (vote_nz) begin
            if (vote_ok) begin
              cand_q <= vote_idx;
              vid_q  <= voter_id;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        StVote: begin
          voted_q[vid_q] <= 1'b1;
          if (cnt_q[cand_q] != '1) cnt_q[cand_q] <= cnt_q[cand_q] + CNT_W'(1);
          total_q <= total_q + TotW'(1);
        end
        StTally: begin
          if (tally_idx_q == '0) begin
            max_q <= cur_cnt;
            win_q <= '0;
            tie_q <= 1'b0;
          end else if (cur_cnt > max_q) begin
            max_q <= cur_cnt;
            win_q <= tally_idx_q;
            tie_q <= 1'b0;
          end else if (cur_cnt == max_q) begin
            tie_q <= 1'b1;
          end
          if (!tally_last) tally_idx_q <= tally_idx_q + CIDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CAND; k++) counts[k*CNT_W +: CNT_W] = cnt_q[k];
    total_votes    = total_q;
    busy           = (state_q == StVote) || (state_q == StLock) || (state_q == StTally);
    voting_enabled = (state_q == StIdle) || busy;
    admin_locked   = (state_q == StLockout);
    winner_valid   = (state_q == StDone);
    winner         = winner_valid ? win_q : '0;
    tie_flag       = winner_valid && tie_q;
    reject         = reject_q;
  end

endmodule

// File: tb/tb_param_voting_machine.sv
// Randomized and directed checks of param_voting_machine against a transaction-level model.
module tb_param_voting_machine;

  localparam int NC = 4;
  localparam int VW = 5;
  localparam int CW = 2;
  localparam int MAXC = (1 << CW) - 1;
  localparam int MAX_TRIES = 3;
  localparam logic [3:0] PW = 4'b1010;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [3:0]      admin_password = '0;
  logic            enable_admin = 1'b0;
  logic            result_mode = 1'b0;
  logic [VW-1:0]   voter_id = '0;
  logic [NC-1:0]   vote = '0;
  logic [NC*CW-1:0] counts;
  logic [VW:0]     total_votes;
  logic [1:0]      winner;
  logic            winner_valid, tie_flag, voting_enabled, busy, reject, admin_locked;

  param_voting_machine #(.NUM_CAND(NC), .VID_W(VW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .admin_password(admin_password),
    .enable_admin(enable_admin), .result_mode(result_mode), .voter_id(voter_id),
    .vote(vote), .counts(counts), .total_votes(total_votes), .winner(winner),
    .winner_valid(winner_valid), .tie_flag(tie_flag), .voting_enabled(voting_enabled),
    .busy(busy), .reject(reject), .admin_locked(admin_locked)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int cnt [NC];
  int total;
  bit voted [2**VW];
  int fails;
  bit authed, locked;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*CW-1:0] exp_counts();
    logic [NC*CW-1:0] r;
    for (int k = 0; k < NC; k++) r[k*CW +: CW] = CW'(cnt[k]);
    return r;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, ".counts"}, 32'(counts), 32'(exp_counts()));
    check({tag, ".total"}, 32'(total_votes), 32'(total));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable_admin = 0; result_mode = 0; vote = '0;
    step();
    check("rst.counts", 32'(counts), 0);
    check("rst.total", 32'(total_votes), 0);
    check("rst.winner", 32'(winner), 0);
    check("rst.wvalid", 32'(winner_valid), 0);
    check("rst.tie", 32'(tie_flag), 0);
    check("rst.ven", 32'(voting_enabled), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.reject", 32'(reject), 0);
    check("rst.locked", 32'(admin_locked), 0);
    reset_n = 1'b1;
    for (int k = 0; k < NC; k++) cnt[k] = 0;
    for (int i = 0; i < 2**VW; i++) voted[i] = 0;
    total = 0; fails = 0; authed = 0; locked = 0;
  endtask

  task automatic auth(input logic [3:0] pw);
    admin_password = pw; enable_admin = 1'b1;
    step();
    enable_admin = 1'b0;
    if (!authed && !locked) begin
      if (pw == PW) begin
        authed = 1; fails = 0;
      end else begin
        fails++;
        if (fails == MAX_TRIES) locked = 1;
      end
    end
    check("auth.locked", 32'(admin_locked), 32'(locked));
    check("auth.ven", 32'(voting_enabled), 32'(authed));
    check("auth.busy", 32'(busy), 0);
  endtask

  task automatic cast(input logic [VW-1:0] id, input logic [NC-1:0] v, input int hold);
    bit ok;
    int c;
    ok = ($countones(v) == 1) && !voted[id];
    c = 0;
    for (int k = 0; k < NC; k++) if (v[k]) c = k;
    voter_id = id; vote = v;
    step();
    check("cast.busy0", 32'(busy), 1);
    check("cast.reject0", 32'(reject), 32'(!ok));
    check_counts("cast.pre");
    if (ok) begin
      if (cnt[c] < MAXC) cnt[c]++;
      total++;
      voted[id] = 1;
    end
    for (int i = 0; i < hold; i++) begin
      step();
      check("cast.hold.busy", 32'(busy), 1);
      check("cast.hold.reject", 32'(reject), 0);
      check_counts("cast.hold");
    end
    vote = '0;
    step();
    check("cast.rel.busy", 32'(busy), 0);
    check("cast.rel.ven", 32'(voting_enabled), 1);
    check_counts("cast.rel");
  endtask

  task automatic tally(input bit with_vote);
    int emax, ewin, nmax;
    emax = -1; ewin = 0; nmax = 0;
    for (int k = 0; k < NC; k++) if (cnt[k] > emax) begin emax = cnt[k]; ewin = k; end
    for (int k = 0; k < NC; k++) if (cnt[k] == emax) nmax++;
    result_mode = 1'b1;
    if (with_vote) begin
      voter_id = VW'($urandom_range(0, 31));
      vote = NC'(1 << $urandom_range(0, NC - 1));
    end
    step();
    result_mode = 1'b0; vote = '0;
    check("tally.reject", 32'(reject), 0);
    check("tally.busy", 32'(busy), 1);
    check("tally.wvalid0", 32'(winner_valid), 0);
    for (int k = 1; k < NC; k++) begin
      step();
      check("tally.scan.busy", 32'(busy), 1);
      check("tally.scan.wvalid", 32'(winner_valid), 0);
      check("tally.scan.winner", 32'(winner), 0);
    end
    step();
    check("tally.wvalid", 32'(winner_valid), 1);
    check("tally.winner", 32'(winner), 32'(ewin));
    check("tally.tie", 32'(tie_flag), 32'(nmax > 1));
    check("tally.busy.done", 32'(busy), 0);
    check("tally.ven", 32'(voting_enabled), 0);
    check_counts("tally");
    // DONE must ignore everything
    voter_id = 5'd30; vote = 4'b0001; result_mode = 1'b1;
    admin_password = PW; enable_admin = 1'b1;
    repeat (3) step();
    vote = '0; result_mode = 0; enable_admin = 0;
    check("done.wvalid", 32'(winner_valid), 1);
    check("done.winner", 32'(winner), 32'(ewin));
    check("done.busy", 32'(busy), 0);
    check("done.reject", 32'(reject), 0);
    check_counts("done");
  endtask

  initial begin
    do_reset();

    // Basic election
    auth(PW);
    cast(5'd3, 4'b0100, 1);
    cast(5'd4, 4'b0100, 1);
    cast(5'd5, 4'b0001, 1);
    tally(1'b0);

    // Duplicate voter and non-one-hot ballot
    do_reset();
    auth(PW);
    cast(5'd3, 4'b0100, 1);
    cast(5'd3, 4'b0001, 1);
    cast(5'd6, 4'b0011, 2);

    // Long hold counts once
    cast(5'd7, 4'b0010, 10);

    // Lockout
    do_reset();
    auth(4'b0000); auth(4'b1111); auth(4'b0101);
    auth(PW);
    voter_id = 5'd1; vote = 4'b0001; result_mode = 1'b1;
    step();
    check("lockout.busy", 32'(busy), 0);
    check("lockout.locked", 32'(admin_locked), 1);
    vote = '0; result_mode = 0;
    check_counts("lockout");
    do_reset();
    auth(PW);

    // Tie between candidates 0 and 1
    cast(5'd1, 4'b0001, 1); cast(5'd2, 4'b0001, 1);
    cast(5'd3, 4'b0010, 1); cast(5'd4, 4'b0010, 1);
    tally(1'b1);

    // Saturation
    do_reset();
    auth(PW);
    for (int i = 0; i < 5; i++) cast(VW'(10 + i), 4'b1000, 1);
    check("sat.cnt3", 32'(counts[3*CW +: CW]), MAXC);
    check("sat.total", 32'(total_votes), 5);

    // All-zero tally
    do_reset();
    auth(PW);
    tally(1'b0);

    // Reset in the middle of a tally
    do_reset();
    auth(PW);
    cast(5'd9, 4'b0100, 1);
    result_mode = 1'b1;
    step(); step();
    result_mode = 1'b0;
    do_reset();

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      int nwrong, nvotes;
      do_reset();
      nwrong = $urandom_range(0, 3);
      for (int i = 0; i < nwrong; i++) begin
        logic [3:0] pw;
        pw = 4'($urandom_range(0, 15));
        if (pw == PW) pw = 4'b0101;
        auth(pw);
      end
      auth(PW);
      if (locked) continue;
      nvotes = $urandom_range(3, 14);
      for (int i = 0; i < nvotes; i++) begin
        logic [NC-1:0] v;
        if ($urandom_range(0, 3) != 0) v = NC'(1 << $urandom_range(0, NC - 1));
        else v = NC'($urandom_range(1, 15));
        cast(VW'($urandom_range(0, 7)), v, $urandom_range(1, 3));
      end
      tally(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_voting_machine.md
PARAM_VOTING_MACHINE -- requirements
Module: param_voting_machine

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NUM_CAND, 4, number of candidates (2..16)
  VID_W, 5, voter ID width; one vote per ID, 2**VID_W voters
  CNT_W, 8, per-candidate count width
  PW_W, 4, admin password width
  PASSWORD, 4'b1010, admin password value
  MAX_TRIES, 3, wrong-password attempts before permanent lockout
  CIDX_W, clog2(NUM_CAND), candidate index width (derived)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  reset_n  in  1  synchronous, active-low reset
  admin_password  in  PW_W  password under test
  enable_admin  in  1  qualifies an authentication attempt
  result_mode  in  1  close polling and start tally
  voter_id  in  VID_W  ID of the current voter
  vote  in  NUM_CAND  candidate select; exactly one bit set when valid
  counts  out  NUM_CAND*CNT_W  flat counts; candidate k at [k*CNT_W +: CNT_W]
  total_votes  out  VID_W+1  accepted-vote total
  winner  out  CIDX_W  winning candidate index
  winner_valid  out  1  winner/tie_flag final
  tie_flag  out  1  another candidate equals the maximum
  voting_enabled  out  1  polling open
  busy  out  1  vote processing or tally in progress
  reject  out  1  one-cycle pulse for a refused ballot
  admin_locked  out  1  authentication locked out
REQ-003 There SHALL be one clock (clk); reset_n SHALL be synchronous and active-low.

Function
REQ-004 States SHALL be AUTH, IDLE, VOTE, LOCK, TALLY, DONE, LOCKOUT.
REQ-005 AUTH, enable_admin=1, password match: next state IDLE, voting_enabled<=1, fail counter cleared.
REQ-006 AUTH, enable_admin=1, mismatch: fail counter +1; the attempt that reaches MAX_TRIES moves to LOCKOUT with admin_locked<=1.
REQ-007 AUTH with enable_admin=0: no change. result_mode and vote are ignored in AUTH.
REQ-008 LOCKOUT SHALL be terminal until reset: no counting, no tally.
REQ-009 IDLE, result_mode=1: enter TALLY. result_mode takes priority over a simultaneous vote; that vote is neither counted nor rejected.
REQ-010 IDLE, vote!=0, vote one-hot, and voter_id not yet marked: capture candidate index and voter_id, enter VOTE.
REQ-011 IDLE, vote!=0 that is not one-hot or has an already-marked voter_id: assert reject for exactly one cycle (the cycle after detection) and enter LOCK; no count changes.
REQ-012 VOTE (exactly one cycle):
  - mark the captured voter
  - increment the captured candidate's count, saturating at 2**CNT_W-1
  - increment total_votes
  - enter LOCK
  - counts change on the clock edge that leaves VOTE.
REQ-013 LOCK: remain until vote==0, then return to IDLE; held inputs never double-count.
REQ-014 TALLY:
  - scan candidates 0..NUM_CAND-1, one per cycle, with a running max and index
  - strictly greater count: update index, clear tie
  - equal count: set tie
  - winner is the lowest index holding the maximum.
REQ-015 Tally latency SHALL be exactly NUM_CAND cycles in TALLY. DONE is then entered with winner_valid<=1 and voting_enabled<=0.
REQ-016 DONE SHALL be terminal until reset. Outputs hold, and all inputs are ignored.
REQ-017 busy SHALL be 1 exactly in VOTE, LOCK and TALLY.
REQ-018 winner and tie_flag SHALL be meaningful only while winner_valid=1, and are 0 otherwise.
REQ-019 All-zero counts at tally SHALL give winner=0 and tie_flag=1.

Reset
REQ-020 reset_n=0 at a clock edge SHALL, from any state including mid-VOTE or mid-TALLY:
  - set state to AUTH
  - clear counts, total_votes, voter marks and the fail counter
  - drive winner, winner_valid, tie_flag, voting_enabled, busy, reject and admin_locked to 0.

Verification
REQ-021 Auth with 1010, then votes: ID3 -> cand 2, ID4 -> cand 2, ID5 -> cand 0, each released; result_mode -> after 4 tally cycles winner=2, tie_flag=0, counts={0:1,1:0,2:2,3:0}, total_votes=3.
REQ-022 ID3 votes twice, then vote=4'b0011 from ID6 -> both refused, reject pulses once each, counts unchanged.
REQ-023 Three wrong passwords -> admin_locked=1, then the correct password is ignored; reset_n low -> admin_locked=0, back in AUTH.
REQ-024 Hold vote cand 1 for 10 cycles -> count[1]=1 only, busy high until release.
REQ-025 Counts cand0=2, cand1=2 -> winner=0, tie_flag=1. With CNT_W=2 and 5 votes for cand 3 -> count[3]=3 (saturated), total_votes=5.
REQ-026 reset_n low during TALLY -> next cycle all outputs 0, state AUTH.
